// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if
//   Groups the upstream and downstream handshakes of one pipeline stage.
//   in_valid / in_data / in_ready   : upstream side (producer -> stage)
//   out_valid / out_data / out_ready: downstream side (stage -> consumer)
//   slave  modport: the stage itself (consumes in_*, produces out_*)
//   master modport: the environment driving the stage
interface pipe_skid_reg_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Two-entry skid-buffered pipeline register. in_ready and out_valid are
//   both registered, so there is no combinational path from out_ready to
//   in_ready. A main register drives out_data; a skid register catches the
//   one beat that arrives while the downstream stalls.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   flush      : synchronous kill of all held entries (beats accept/dequeue)
//   cnt_clr    : synchronous clear of the performance counters
//   bus        : handshake bundle (slave modport), see pipe_skid_reg_if
//   occupancy  : live entries held (0..2)
//   stall_cnt  : saturating count of cycles with out_valid=1, out_ready=0
//   bubble_cnt : saturating count of cycles with out_valid=0, out_ready=1
module pipe_skid_reg #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  NOP_VALUE = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               cnt_clr,
    pipe_skid_reg_if.slave     bus,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    // Encodings double as the occupancy value.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             accept;
    logic             dequeue;

    assign accept  = bus.in_valid & in_ready_q;
    assign dequeue = out_valid_q & bus.out_ready;

    // ------------------------------------------------------------------
    // State / storage register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= NOP_VALUE;
            skid_q      <= NOP_VALUE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            // Handshake outputs are registered copies derived from the next
            // state, so they always agree with occupancy.
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath steering
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = bus.in_data;
                    end
                end
                ONE: begin
                    if (accept && dequeue) begin
                        main_d = bus.in_data;
                    end else if (accept) begin
                        // Downstream stalled: park the new beat in skid.
                        state_d = FULL;
                        skid_d  = bus.in_data;
                    end else if (dequeue) begin
                        state_d = EMPTY;
                        main_d  = NOP_VALUE;
                    end
                end
                FULL: begin
                    // in_ready is low here, so no accept can coincide.
                    if (dequeue) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Performance counters (sampled on the registered, pre-flush outputs)
    // ------------------------------------------------------------------
    logic stall_evt;
    logic bubble_evt;

    assign stall_evt  = out_valid_q & ~bus.out_ready;
    assign bubble_evt = ~out_valid_q & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (bubble_evt && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign occupancy     = state_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg
//   Directed scenarios followed by a long random run. The reference is a
//   FIFO queue of accepted beats with a two-entry capacity plus saturating
//   counters; every cycle the DUT outputs are compared against it.
module tb_pipe_skid_reg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             cnt_clr;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    pipe_skid_reg_if #(.WIDTH(WIDTH)) bus ();

    pipe_skid_reg #(
        .WIDTH     (WIDTH),
        .NOP_VALUE ('0),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .bus        (bus),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference state
    logic [WIDTH-1:0] mq[$];
    bit               m_live;     // in_ready may be high (an edge has passed since reset)
    int unsigned      m_stall;
    int unsigned      m_bubble;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_live   = 1'b0;
        m_stall  = 0;
        m_bubble = 0;
    endtask

    task automatic check_outputs();
        logic [63:0] exp_data;
        exp_data = (mq.size() != 0) ? 64'(mq[0]) : 64'd0;
        check_val("occupancy",  64'(occupancy),     64'(mq.size()));
        check_val("out_valid",  64'(bus.out_valid), 64'(mq.size() != 0));
        check_val("in_ready",   64'(bus.in_ready),  64'(m_live && mq.size() < 2));
        check_val("out_data",   64'(bus.out_data),  exp_data);
        check_val("stall_cnt",  64'(stall_cnt),     64'(m_stall));
        check_val("bubble_cnt", 64'(bubble_cnt),    64'(m_bubble));
    endtask

    // Apply one rising edge to the reference, using the inputs the DUT sees.
    task automatic model_edge();
        bit ov, acc, deq;
        ov  = (mq.size() != 0);
        acc = bus.in_valid && m_live && (mq.size() < 2) && !flush;
        deq = ov && bus.out_ready && !flush;
        if (cnt_clr) begin
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (ov && !bus.out_ready && m_stall < CNT_MAX)  m_stall++;
            if (!ov && bus.out_ready && m_bubble < CNT_MAX) m_bubble++;
        end
        if (flush) begin
            mq.delete();
        end else begin
            if (deq) void'(mq.pop_front());
            if (acc) mq.push_back(bus.in_data);
        end
        m_live = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
    endtask

    initial begin
        rst     = 1'b1;
        flush   = 1'b0;
        cnt_clr = 1'b0;
        drive(1'b0, '0, 1'b0);
        model_reset();
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming at full rate
        step();
        drive(1'b1, 32'h11, 1'b1); step();
        drive(1'b1, 32'h22, 1'b1); step();
        drive(1'b1, 32'h33, 1'b1); step();
        check_val("stream_occ", 64'(occupancy), 64'd1);
        drive(1'b0, '0, 1'b1); step(); step();

        // Back-pressure fills the skid register
        drive(1'b1, 32'hA1, 1'b1); step();
        drive(1'b1, 32'hB2, 1'b0); step();
        drive(1'b0, '0, 1'b0); step();
        check_val("bp_full_occ", 64'(occupancy),    64'd2);
        check_val("bp_full_rdy", 64'(bus.in_ready), 64'd0);
        drive(1'b0, '0, 1'b1); step(); step(); step();
        check_val("bp_drain_occ",  64'(occupancy),    64'd0);
        check_val("bp_drain_data", 64'(bus.out_data), 64'd0);

        // Flush while FULL with a competing offer
        drive(1'b1, 32'hC1, 1'b0); step();
        drive(1'b1, 32'hC2, 1'b0); step();
        flush = 1'b1;
        drive(1'b1, 32'hCC, 1'b0); step();
        flush = 1'b0;
        drive(1'b0, '0, 1'b1);
        check_val("flush_occ",   64'(occupancy),     64'd0);
        check_val("flush_valid", 64'(bus.out_valid), 64'd0);
        check_val("flush_data",  64'(bus.out_data),  64'd0);
        step(); step(); step();

        // Stall counter saturation and clear
        cnt_clr = 1'b1; step();
        cnt_clr = 1'b0;
        drive(1'b1, 32'h5A, 1'b0); step();
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        check_val("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
        cnt_clr = 1'b1; step();
        cnt_clr = 1'b0;
        check_val("stall_clr", 64'(stall_cnt), 64'd0);

        // Asynchronous reset between edges while FULL
        drive(1'b1, 32'h77, 1'b0); step();
        drive(1'b0, '0, 1'b0);
        check_val("pre_rst_occ", 64'(occupancy), 64'd2);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        #1;
        rst = 1'b0;
        drive(1'b0, '0, 1'b1);
        step();
        check_val("rdy_after_rel", 64'(bus.in_ready), 64'd1);
        step(); step();

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(1)), $urandom(), 1'($urandom_range(1)));
            flush   = ($urandom_range(63) == 0);
            cnt_clr = ($urandom_range(127) == 0);
            step();
            if (occupancy > 2'd2) check_val("occ_bound", 64'(occupancy), 64'd2);
        end
        flush   = 1'b0;
        cnt_clr = 1'b0;
        drive(1'b0, '0, 1'b1);
        step(); step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 Parameter NOP_VALUE, default {WIDTH{1'b0}}, payload value presented for a bubble, flush or reset.
REQ-003 Parameter CNT_W, default 16, width of the performance counters.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous kill of all held entries.
REQ-007 cnt_clr  input  1  synchronous clear of the performance counters.
REQ-008 in_valid  input  1  upstream offers in_data.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 in_ready  output  1  stage can accept this cycle.
REQ-011 out_valid  output  1  out_data holds a live entry.
REQ-012 out_data  output  WIDTH  downstream payload.
REQ-013 out_ready  input  1  downstream consumes this cycle.
REQ-014 occupancy  output  2  live entries held (0..2).
REQ-015 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
REQ-016 bubble_cnt  output  CNT_W  cycles with out_valid=0 and out_ready=1.

Function
REQ-017 Storage: one main register (drives out_data) and one skid register; state EMPTY/ONE/FULL encoded as occupancy 0/1/2.
REQ-018 in_ready = (occupancy != 2), registered; it has no combinational path from out_ready.
REQ-019 out_valid = (occupancy != 0), registered.
REQ-020 Accept occurs when in_valid & in_ready; dequeue occurs when out_valid & out_ready.
REQ-021 EMPTY + accept -> ONE, main <= in_data; latency from input to output is one cycle.
REQ-022 ONE + accept + dequeue -> ONE, main <= in_data.
REQ-023 ONE + accept + no dequeue -> FULL, skid <= in_data, main is held.
REQ-024 ONE + dequeue + no accept -> EMPTY, main <= NOP_VALUE.
REQ-025 FULL + dequeue -> ONE, main <= skid, skid <= NOP_VALUE; there is no accept because in_ready=0.
REQ-026 Otherwise the state and both registers hold their values (stall).
REQ-027 Entries leave the stage in acceptance order; no entry is dropped or duplicated outside a flush.
REQ-028 flush=1 takes priority over accept and dequeue: next state EMPTY, main and skid <= NOP_VALUE, and in_valid is ignored that cycle.
REQ-029 out_data equals NOP_VALUE whenever occupancy=0.
REQ-030 stall_cnt increments when out_valid & ~out_ready; bubble_cnt increments when ~out_valid & out_ready.
REQ-031 Both counters saturate at 2^CNT_W-1 and do not wrap.
REQ-032 cnt_clr=1 zeroes both counters that cycle with no increment applied; cnt_clr has priority over increments.
REQ-033 flush does not affect the counters; counter conditions are sampled on pre-flush outputs.

Reset
REQ-034 rst=1 asynchronously forces occupancy=0, out_valid=0, in_ready=0, main=skid=NOP_VALUE, and both counters to 0.
REQ-035 in_ready rises on the first clk edge after rst deasserts.
REQ-036 rst asserted mid-transfer discards all entries; nothing is presented after release until a new accept.
REQ-037 rst overrides flush, cnt_clr and every handshake.

Verification
REQ-038 Streaming (WIDTH=32, out_ready=1): in 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each; occupancy stays 1; in_ready stays 1.
REQ-039 Back-pressure: accept 0xA1, then drop out_ready and offer 0xB2 -> occupancy=2, in_ready=0; raise out_ready -> outputs 0xA1 then 0xB2, then occupancy=0 and out_data=NOP_VALUE.
REQ-040 Flush while FULL with in_valid=1 and in_data=0xCC -> next cycle occupancy=0, out_valid=0, out_data=0; 0xCC never appears.
REQ-041 Counters (CNT_W=4): hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt=15, saturated; pulse cnt_clr -> 0 next cycle.
REQ-042 Async reset between clock edges while FULL -> outputs zero immediately without a clk edge; in_ready=1 one edge after release.
REQ-043 Random in_valid/out_ready for 10k cycles -> the output sequence exactly matches the accepted sequence, and occupancy never exceeds 2.
